// File: rtl/ipf_pkg.sv
// Shared encodings, FSM states and LCU size helpers for the IPF stream filter.
package ipf_pkg;

    // Filter modes as seen by the pixel classifier
    localparam logic [1:0] IPF_OFF = 2'd0;
    localparam logic [1:0] IPF_BO  = 2'd1;
    localparam logic [1:0] IPF_EO0 = 2'd2;

    // lcu_size encodings
    localparam logic [1:0] LCU_16  = 2'd0;
    localparam logic [1:0] LCU_32  = 2'd1;
    localparam logic [1:0] LCU_64  = 2'd2;
    localparam logic [1:0] LCU_128 = 2'd3;

    // Width of the in-LCU x/y counters (largest LCU is 128)
    localparam int CNT_W = 7;

    // Edge-offset categories; the low two bits select the offset
    typedef enum logic [2:0] {
        EO_VALLEY  = 3'd0,
        EO_CONCAVE = 3'd1,
        EO_CONVEX  = 3'd2,
        EO_PEAK    = 3'd3,
        EO_NONE    = 3'd4
    } eo_cat_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } ipf_state_e;

    // log2 of the LCU edge length
    function automatic logic [2:0] lcu_log2(input logic [1:0] size);
        return 3'd4 + {1'b0, size};
    endfunction

    // Last x/y index inside an LCU (L-1)
    function automatic logic [CNT_W-1:0] lcu_last(input logic [1:0] size);
        logic [CNT_W:0] len;
        len = (CNT_W+1)'(1) << lcu_log2(size);
        return CNT_W'(len - (CNT_W+1)'(1));
    endfunction

endpackage

// File: rtl/ipf_pix_classify.sv
// Combinational per-pixel filter: picks a BO or EO-0 offset and clips the sum.
module ipf_pix_classify
    import ipf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OFF_W  = 4
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [DATA_W-1:0]  c_i,
    input  logic [DATA_W-1:0]  b_i,
    input  logic [1:0]         mode_i,
    input  logic [4:0]         band_pos_i,
    input  logic [4*OFF_W-1:0] offset_i,
    input  logic               edge_i,
    output logic [DATA_W-1:0]  pix_o
);

    localparam int SUM_W = DATA_W + 2;
    localparam logic signed [SUM_W-1:0] PIX_MAX = {2'b00, {DATA_W{1'b1}}};

    function automatic eo_cat_e eo_class(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] c,
                                         input logic [DATA_W-1:0] b);
        if (c < a && c < b)                           return EO_VALLEY;
        if ((c < a && c == b) || (c == a && c < b))   return EO_CONCAVE;
        if ((c > a && c == b) || (c == a && c > b))   return EO_CONVEX;
        if (c > a && c > b)                           return EO_PEAK;
        return EO_NONE;
    endfunction

    function automatic logic [DATA_W-1:0] clip_pix(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1]) return '0;
        if (s > PIX_MAX) return '1;
        return s[DATA_W-1:0];
    endfunction

    logic signed [OFF_W-1:0] off_arr [4];
    logic [4:0]              band;
    logic [4:0]              k_bo;
    logic [1:0]              k_sel;
    logic                    use_off;
    eo_cat_e                 cat;
    logic signed [SUM_W-1:0] off_ext;
    logic signed [SUM_W-1:0] sum;

    // Select the offset for this pixel and apply it with saturation
    always_comb begin
        use_off = 1'b0;
        k_sel   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            off_arr[i] = offset_i[OFF_W*i +: OFF_W];
        end
        band = c_i[DATA_W-1 -: 5];
        // Modulo-32 distance lets the four-band window wrap past band 31
        k_bo = band - band_pos_i;
        cat  = eo_class(a_i, c_i, b_i);
        case (mode_i)
            IPF_BO: begin
                if (k_bo[4:2] == 3'b000) begin
                    use_off = 1'b1;
                    k_sel   = k_bo[1:0];
                end
            end
            IPF_EO0: begin
                if (!edge_i && cat != EO_NONE) begin
                    use_off = 1'b1;
                    k_sel   = cat[1:0];
                end
            end
            default: begin
                use_off = 1'b0;
            end
        endcase
        off_ext = use_off ? {{(SUM_W-OFF_W){off_arr[k_sel][OFF_W-1]}}, off_arr[k_sel]} : '0;
        sum     = $signed({2'b00, c_i}) + off_ext;
        pix_o   = clip_pix(sum);
    end

endmodule

// File: rtl/ipf_stream_core.sv
// Streaming in-loop pixel filter: LCU counters, one-pixel lookahead window,
// row-flush FSM and global raster address generation.
module ipf_stream_core
    import ipf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OFF_W    = 4,
    parameter int IMG_W    = 128,
    parameter int LCU_XY_W = 3,
    parameter int ADDR_W   = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_en,
    input  logic [DATA_W-1:0]   din,
    input  logic [1:0]          ipf_type,
    input  logic [4:0]          ipf_band_pos,
    input  logic                ipf_wo_class,
    input  logic [4*OFF_W-1:0]  ipf_offset,
    input  logic [LCU_XY_W-1:0] lcu_x,
    input  logic [LCU_XY_W-1:0] lcu_y,
    input  logic [1:0]          lcu_size,
    output logic                busy,
    output logic                out_en,
    output logic [DATA_W-1:0]   dout,
    output logic [ADDR_W-1:0]   dout_addr,
    output logic                finish
);

    localparam int IMG_LOG = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(IMG_W*IMG_W - 1);

    ipf_state_e          state_q, state_d;
    logic [CNT_W-1:0]    x_q, x_d;
    logic [CNT_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   prev_q, cur_q;
    logic [1:0]          mode_q;
    logic [1:0]          size_q;
    logic [4:0]          band_pos_q;
    logic [4*OFF_W-1:0]  offset_q;
    logic [LCU_XY_W-1:0] lcu_x_q, lcu_y_q;
    logic                out_en_q;
    logic [DATA_W-1:0]   dout_q;
    logic [ADDR_W-1:0]   addr_q;

    logic                accept, flush, row_last, lcu_first, out_fire, edge_pix;
    logic [CNT_W-1:0]    l_last, out_x;
    logic [ADDR_W-1:0]   row_base, col_base, out_addr;
    logic [1:0]          mode_in;
    logic [DATA_W-1:0]   pix_filt;

    // Accept/flush decode, output pixel position and its raster address
    always_comb begin
        l_last    = lcu_last(size_q);
        flush     = (state_q == ST_FLUSH);
        accept    = in_en && (state_q == ST_RUN);
        row_last  = (x_q == l_last);
        lcu_first = (x_q == '0) && (y_q == '0);
        // The held pixel leaves when its right neighbour arrives, or in FLUSH at row end
        out_fire  = (accept && (x_q != '0)) || flush;
        out_x     = flush ? x_q : x_q - CNT_W'(1);
        // Row-start and row-end pixels have no in-row neighbour on one side
        edge_pix  = flush || (x_q == CNT_W'(1));
        row_base  = (ADDR_W'(lcu_y_q) << lcu_log2(size_q)) + ADDR_W'(y_q);
        col_base  = (ADDR_W'(lcu_x_q) << lcu_log2(size_q)) + ADDR_W'(out_x);
        out_addr  = (row_base << IMG_LOG) + col_base;
        mode_in   = IPF_OFF;
        if (!ipf_wo_class && (ipf_type == IPF_BO || ipf_type == IPF_EO0)) begin
            mode_in = ipf_type;
        end
    end

    // Next values of the x/y position and frame output counter
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        if (accept && !row_last) begin
            x_d = x_q + CNT_W'(1);
        end
        if (flush) begin
            x_d = '0;
            y_d = (y_q == l_last) ? '0 : y_q + CNT_W'(1);
        end
        if (out_fire) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    // FSM next state and the busy/finish outputs it drives
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        finish  = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy = 1'b0;
                if (accept && row_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = (cnt_q == LAST_CNT) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                finish = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state: FSM, counters and the latched mode/size of the current LCU
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= IPF_OFF;
            size_q  <= LCU_16;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            if (accept && lcu_first) begin
                mode_q <= mode_in;
                size_q <= lcu_size;
            end
        end
    end

    // Lookahead window and per-LCU data parameters
    always_ff @(posedge clk) begin
        if (accept) begin
            prev_q <= cur_q;
            cur_q  <= din;
        end
        if (accept && lcu_first) begin
            band_pos_q <= ipf_band_pos;
            offset_q   <= ipf_offset;
            lcu_x_q    <= lcu_x;
            lcu_y_q    <= lcu_y;
        end
    end

    ipf_pix_classify #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_classify (
        .a_i        (prev_q),
        .c_i        (cur_q),
        .b_i        (din),
        .mode_i     (mode_q),
        .band_pos_i (band_pos_q),
        .offset_i   (offset_q),
        .edge_i     (edge_pix),
        .pix_o      (pix_filt)
    );

    // Registered output pixel and address
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_en_q <= 1'b0;
            dout_q   <= '0;
            addr_q   <= '0;
        end else begin
            out_en_q <= out_fire;
            if (out_fire) begin
                dout_q <= pix_filt;
                addr_q <= out_addr;
            end
        end
    end

    assign out_en    = out_en_q;
    assign dout      = dout_q;
    assign dout_addr = addr_q;

endmodule

// File: tb/tb_ipf_stream_core.sv
// Directed bench for ipf_stream_core on a 32x32 frame of 16x16 LCUs.
module tb_ipf_stream_core;

    localparam int DATA_W   = 8;
    localparam int OFF_W    = 4;
    localparam int IMG_W    = 32;
    localparam int LCU_XY_W = 3;
    localparam int ADDR_W   = 10;
    localparam int NPIX     = IMG_W * IMG_W;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_en = 1'b0;
    logic [DATA_W-1:0]   din = '0;
    logic [1:0]          ipf_type = '0;
    logic [4:0]          ipf_band_pos = '0;
    logic                ipf_wo_class = 1'b0;
    logic [4*OFF_W-1:0]  ipf_offset = '0;
    logic [LCU_XY_W-1:0] lcu_x = '0;
    logic [LCU_XY_W-1:0] lcu_y = '0;
    logic [1:0]          lcu_size = '0;
    logic                busy;
    logic                out_en;
    logic [DATA_W-1:0]   dout;
    logic [ADDR_W-1:0]   dout_addr;
    logic                finish;

    ipf_stream_core #(
        .DATA_W   (DATA_W),
        .OFF_W    (OFF_W),
        .IMG_W    (IMG_W),
        .LCU_XY_W (LCU_XY_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_en        (in_en),
        .din          (din),
        .ipf_type     (ipf_type),
        .ipf_band_pos (ipf_band_pos),
        .ipf_wo_class (ipf_wo_class),
        .ipf_offset   (ipf_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .busy         (busy),
        .out_en       (out_en),
        .dout         (dout),
        .dout_addr    (dout_addr),
        .finish       (finish)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int phase  = 0;

    int pre_cnt = 0;
    int pre_pix  [64];
    int pre_addr [64];
    int mon_cnt = 0;
    int got_pix  [NPIX];
    int wr_cnt   [NPIX];
    int addr_log [NPIX];

    int bo_row [4]  = '{80, 104, 127, 90};
    int eo_row [16] = '{10, 5, 10, 10, 12, 12, 9, 9, 9, 9, 9, 9, 9, 9, 20, 3};

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (out_en) begin
            if (phase == 1) begin
                if (pre_cnt < 64) begin
                    pre_pix[pre_cnt]  = int'(dout);
                    pre_addr[pre_cnt] = int'(dout_addr);
                end
                pre_cnt++;
            end else if (phase == 2) begin
                if (mon_cnt < NPIX) addr_log[mon_cnt] = int'(dout_addr);
                got_pix[dout_addr] = int'(dout);
                wr_cnt[dout_addr]++;
                mon_cnt++;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus pixel for LCU n at (y, x); n=9 is the stream cut by the mid-LCU reset
    function automatic int pix_val(input int n, input int y, input int x);
        case (n)
            0: return (y == 0 && x < 4) ? bo_row[x] : 200;
            1: begin
                if (y == 0 && x == 0) return 255;
                if (y == 0 && x == 1) return 3;
                return 200;
            end
            2: return (y == 0) ? eo_row[x] : 50;
            3: return (y == 0 && x == 0) ? 80 : 200;
            default: begin
                if (y == 0 && x == 0) return 0;
                if (y == 0 && x == 1) return 7;
                return 100;
            end
        endcase
    endfunction

    task automatic set_lcu(input int t, input int bp, input bit wo, input int off,
                           input int lx, input int ly);
        ipf_type     = 2'(t);
        ipf_band_pos = 5'(bp);
        ipf_wo_class = wo;
        ipf_offset   = 16'(off);
        lcu_x        = 3'(lx);
        lcu_y        = 3'(ly);
        lcu_size     = 2'd0;
    endtask

    // Present one pixel, wait for acceptance, and check the row-end flush bubble
    task automatic send_pix(input int v, input bit row_end, input bit frame_end);
        int guard;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", int'(busy), 0);
        din   = 8'(v);
        in_en = 1'b1;
        @(negedge clk);
        in_en = 1'b0;
        if (row_end) begin
            check("flush_busy", int'(busy), 1);
            @(negedge clk);
            check("after_flush_busy", int'(busy), frame_end ? 1 : 0);
        end
    endtask

    // Stream a 16x16 LCU; the side ports are scrambled after pixel 0 to prove latching
    task automatic send_lcu(input int n, input bit last_lcu);
        for (int i = 0; i < 256; i++) begin
            send_pix(pix_val(n, i / 16, i % 16), (i % 16) == 15, last_lcu && (i == 255));
            if (i == 0) begin
                ipf_type     = 2'd0;
                ipf_offset   = '0;
                ipf_wo_class = ~ipf_wo_class;
                ipf_band_pos = 5'd17;
                lcu_x        = 3'd7;
                lcu_y        = 3'd7;
            end
            if (i % 7 == 3) repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_busy",   int'(busy),      0);
        check("rst_out_en", int'(out_en),    0);
        check("rst_dout",   int'(dout),      0);
        check("rst_addr",   int'(dout_addr), 0);
        check("rst_finish", int'(finish),    0);

        // BO low-clip stream, interrupted by a reset after 37 pixels
        phase = 1;
        reset = 1'b1;
        set_lcu(1, 0, 1'b0, 16'h000D, 0, 0);
        for (int i = 0; i < 37; i++) begin
            send_pix(pix_val(9, i / 16, i % 16), (i % 16) == 15, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_en", int'(out_en),    0);
        check("midrst_busy",   int'(busy),      0);
        check("midrst_addr",   int'(dout_addr), 0);
        reset = 1'b1;
        phase = 2;
        check("pre_count",     pre_cnt,     36);
        check("bo_low_clip",   pre_pix[0],  0);
        check("bo_k0_neg",     pre_pix[1],  4);
        check("pre_addr_row1", pre_addr[16], 32);
        check("pre_addr_last", pre_addr[35], 67);

        // Full frame of four LCUs
        set_lcu(1, 10, 1'b0, 16'hF325, 0, 0);
        send_lcu(0, 1'b0);
        set_lcu(1, 31, 1'b0, 16'h0034, 1, 0);
        send_lcu(1, 1'b0);
        set_lcu(2, 0, 1'b0, 16'h4321, 0, 1);
        send_lcu(2, 1'b0);
        set_lcu(1, 10, 1'b1, 16'hF325, 1, 1);
        send_lcu(3, 1'b1);
        repeat (2) @(negedge clk);

        check("out_count",  mon_cnt,          NPIX);
        check("done_finish", int'(finish),    1);
        check("done_busy",   int'(busy),      1);

        check("bo_80",       got_pix[0],   85);
        check("bo_104",      got_pix[1],   103);
        check("bo_127",      got_pix[2],   127);
        check("bo_90",       got_pix[3],   92);
        check("bo_outside",  got_pix[4],   200);
        check("bo_wrap_clip", got_pix[16], 255);
        check("bo_wrap_k1",  got_pix[17],  6);
        check("eo_x0",       got_pix[512], 10);
        check("eo_valley",   got_pix[513], 6);
        check("eo_convex",   got_pix[514], 13);
        check("eo_concave",  got_pix[515], 12);
        check("eo_convex2",  got_pix[516], 15);
        check("eo_peak",     got_pix[526], 24);
        check("eo_row_end",  got_pix[527], 3);
        check("eo_row1_x0",  got_pix[544], 50);
        check("wo_class",    got_pix[528], 80);
        check("wo_other",    got_pix[529], 200);

        check("addr_first",  addr_log[0],   0);
        check("addr_lcu1_y1", addr_log[272], 48);
        check("addr_lcu3",   addr_log[768], 528);
        check("addr_last",   addr_log[NPIX-1], NPIX - 1);

        bad = 0;
        seen = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (wr_cnt[a] != 1) bad++;
            if (wr_cnt[a] != 0) seen++;
        end
        check("addr_once_bad", bad,  0);
        check("addr_covered",  seen, NPIX);

        // DONE holds and ignores further input
        in_en = 1'b1;
        din   = 8'd42;
        repeat (10) @(negedge clk);
        check("hold_finish", int'(finish), 1);
        check("hold_busy",   int'(busy),   1);
        check("hold_out_en", int'(out_en), 0);
        check("hold_count",  mon_cnt,      NPIX);
        in_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
